// File: rtl/program_counter_ras_pkg.sv
// Package for the fetch-stage program counter with return-address stack.
// Contents:
//   pc_op_e           3-bit operation code sampled by the PC every clock
//   PC_*_DEF          default address width, page-offset width, RAS depth
//   pc_cond_taken()   condition decode shared by the JxZR / BxZR operations
package program_counter_ras_pkg;

  typedef enum logic [2:0] {
    PC_NOP  = 3'd0,
    PC_JIZR = 3'd1,
    PC_JNZR = 3'd2,
    PC_BIZR = 3'd3,
    PC_BNZR = 3'd4,
    PC_CALL = 3'd5,
    PC_RET  = 3'd6,
    PC_LJ   = 3'd7
  } pc_op_e;

  localparam int PC_AW_DEF        = 10;
  localparam int PC_OW_DEF        = 8;
  localparam int PC_RAS_DEPTH_DEF = 4;

  // "If zero" variants take the branch when zero is set, "if not zero"
  // variants when it is clear. Only meaningful for the four conditional ops.
  function automatic logic pc_cond_taken(input pc_op_e op, input logic zero);
    logic taken;
    if (op == PC_JIZR || op == PC_BIZR) taken = zero;
    else                                taken = ~zero;
    return taken;
  endfunction

endpackage

// File: rtl/program_counter_ras_if.sv
// Bundle of control inputs and status outputs of program_counter_ras.
// Optional macro: PC_STALL_EN adds the stall signal.
// Signals:
//   start, start_address  synchronous load of the program entry point
//   op, zero              operation code and zero flag of the tested register
//   res                   absolute target for JIZR/JNZR
//   rz                    in-page offset for BIZR/BNZR/LJ
//   lj_page               page for LJ
//   subroutine            CALL target
//   stall                 hold all state (PC_STALL_EN only)
//   rp                    current instruction address
//   ras_depth             number of valid return-stack entries
//   ras_err               sticky return-stack overflow/underflow flag
// Modports: master drives the controls (CPU / bench), slave is the PC.
interface program_counter_ras_if
  import program_counter_ras_pkg::*;
#(
  parameter int AW        = PC_AW_DEF,
  parameter int OW        = PC_OW_DEF,
  parameter int RAS_DEPTH = PC_RAS_DEPTH_DEF
);
  localparam int PW = AW - OW;
  localparam int DW = $clog2(RAS_DEPTH + 1);

  logic          start;
  logic [AW-1:0] start_address;
  logic [2:0]    op;
  logic          zero;
  logic [AW-1:0] res;
  logic [OW-1:0] rz;
  logic [PW-1:0] lj_page;
  logic [AW-1:0] subroutine;
`ifdef PC_STALL_EN
  logic          stall;
`endif
  logic [AW-1:0] rp;
  logic [DW-1:0] ras_depth;
  logic          ras_err;

`ifdef PC_STALL_EN
  modport master (
    output start, start_address, op, zero, res, rz, lj_page, subroutine, stall,
    input  rp, ras_depth, ras_err
  );
  modport slave (
    input  start, start_address, op, zero, res, rz, lj_page, subroutine, stall,
    output rp, ras_depth, ras_err
  );
`else
  modport master (
    output start, start_address, op, zero, res, rz, lj_page, subroutine,
    input  rp, ras_depth, ras_err
  );
  modport slave (
    input  start, start_address, op, zero, res, rz, lj_page, subroutine,
    output rp, ras_depth, ras_err
  );
`endif

endinterface

// File: rtl/program_counter_ras_pc_ras.sv
// pc_ras: return-address LIFO of RAS_DEPTH entries x AW bits plus a depth count.
// Ports:
//   clk, reset   clock, asynchronous active-high reset (clears depth only)
//   clear        synchronous depth clear (program restart)
//   push, pop    push_data onto / drop the top entry; ignored when full / empty
//   push_data    address to store
//   top          most recently pushed entry (valid when !empty)
//   depth        valid entry count, full / empty status
// The storage itself is never reset: entries above depth are don't-care.
module pc_ras
  import program_counter_ras_pkg::*;
#(
  parameter int AW        = PC_AW_DEF,
  parameter int RAS_DEPTH = PC_RAS_DEPTH_DEF,
  localparam int DW       = $clog2(RAS_DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          push,
  input  logic          pop,
  input  logic [AW-1:0] push_data,
  output logic [AW-1:0] top,
  output logic [DW-1:0] depth,
  output logic          full,
  output logic          empty
);
  localparam int IW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

  logic [AW-1:0] stack_mem [RAS_DEPTH];
  logic [DW-1:0] depth_reg;
  logic [DW-1:0] depth_m1;
  logic [IW-1:0] wr_idx;
  logic [IW-1:0] top_idx;

  assign full     = (depth_reg == DW'(RAS_DEPTH));
  assign empty    = (depth_reg == '0);
  assign depth_m1 = depth_reg - DW'(1);
  // Entry i lives at index i, so the next free slot is the current depth.
  assign wr_idx   = depth_reg[IW-1:0];
  assign top_idx  = depth_m1[IW-1:0];
  assign top      = stack_mem[top_idx];
  assign depth    = depth_reg;

  always_ff @(posedge clk) begin
    if (push && !full) stack_mem[wr_idx] <= push_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      depth_reg <= '0;
    end else if (clear) begin
      depth_reg <= '0;
    end else if (push && !full) begin
      depth_reg <= depth_reg + DW'(1);
    end else if (pop && !empty) begin
      depth_reg <= depth_m1;
    end
  end

endmodule

// File: rtl/program_counter_ras.sv
// program_counter_ras: next-address logic and PC register of the 9-bit CPU
// fetch stage, with an internal return-address stack for CALL/RET.
// Optional macro: PC_STALL_EN adds a stall input that freezes all state.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-high reset: rp=0, empty stack, ras_err=0
//   bus    program_counter_ras_if.slave: start/op/operand inputs, rp,
//          ras_depth and ras_err outputs
// Priority per edge: start > stall > op. rp is a single registered stage.
module program_counter_ras
  import program_counter_ras_pkg::*;
#(
  parameter int AW        = PC_AW_DEF,
  parameter int OW        = PC_OW_DEF,
  parameter int RAS_DEPTH = PC_RAS_DEPTH_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  program_counter_ras_if.slave bus
);
  localparam int DW = $clog2(RAS_DEPTH + 1);

  logic [AW-1:0] rp_reg;
  logic [AW-1:0] rp_next;
  logic [AW-1:0] rp_inc;
  logic          ras_err_reg;
  logic          err_set;
  logic          do_push;
  logic          do_pop;
  logic          hold;
  logic          advance;
  pc_op_e        op_e;

  logic [AW-1:0] ras_top;
  logic [DW-1:0] ras_depth;
  logic          ras_full;
  logic          ras_empty;

`ifdef PC_STALL_EN
  assign hold = bus.stall;
`else
  assign hold = 1'b0;
`endif

  // Stack updates only happen on cycles where the op is actually executed.
  assign advance = !bus.start && !hold;
  assign op_e    = pc_op_e'(bus.op);
  assign rp_inc  = rp_reg + AW'(1);

  always_comb begin
    rp_next = rp_inc;
    do_push = 1'b0;
    do_pop  = 1'b0;
    err_set = 1'b0;
    case (op_e)
      PC_JIZR, PC_JNZR: begin
        if (pc_cond_taken(op_e, bus.zero)) rp_next = bus.res;
      end
      PC_BIZR, PC_BNZR: begin
        if (pc_cond_taken(op_e, bus.zero)) rp_next = {rp_reg[AW-1:OW], bus.rz};
      end
      PC_LJ: begin
        rp_next = {bus.lj_page, bus.rz};
      end
      PC_CALL: begin
        // The jump is taken even when the stack is full; only the push is lost.
        rp_next = bus.subroutine;
        do_push = 1'b1;
        err_set = ras_full;
      end
      PC_RET: begin
        if (!ras_empty) begin
          rp_next = ras_top;
          do_pop  = 1'b1;
        end else begin
          err_set = 1'b1;
        end
      end
      default: rp_next = rp_inc;
    endcase
  end

  pc_ras #(
    .AW        (AW),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .reset     (reset),
    .clear     (bus.start),
    .push      (do_push && advance),
    .pop       (do_pop && advance),
    .push_data (rp_inc),
    .top       (ras_top),
    .depth     (ras_depth),
    .full      (ras_full),
    .empty     (ras_empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rp_reg      <= '0;
      ras_err_reg <= 1'b0;
    end else if (bus.start) begin
      rp_reg      <= bus.start_address;
      ras_err_reg <= 1'b0;
    end else if (!hold) begin
      rp_reg      <= rp_next;
      ras_err_reg <= ras_err_reg | err_set;
    end
  end

  assign bus.rp        = rp_reg;
  assign bus.ras_depth = ras_depth;
  assign bus.ras_err   = ras_err_reg;

endmodule

// File: tb/tb_program_counter_ras.sv
// Directed bench for program_counter_ras (AW=10, OW=8, RAS_DEPTH=4).
// Build with PC_STALL_EN defined to include the stall scenarios.
module tb_program_counter_ras;
  import program_counter_ras_pkg::*;

  localparam int AW = 10;
  localparam int OW = 8;
  localparam int RD = 4;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  program_counter_ras_if #(.AW(AW), .OW(OW), .RAS_DEPTH(RD)) bus ();

  program_counter_ras #(.AW(AW), .OW(OW), .RAS_DEPTH(RD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      $display("ok   %-14s observed=%0h expected=%0h", tag, obs, exp);
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are then stable again 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input pc_op_e op);
    bus.op = op;
    step();
  endtask

  task automatic do_start(input logic [AW-1:0] addr);
    bus.start         = 1'b1;
    bus.start_address = addr;
    step();
    bus.start         = 1'b0;
  endtask

  task automatic chk3(input string tag, input logic [AW-1:0] rp,
                      input int depth, input logic err);
    check({tag, ".rp"}, 32'(bus.rp), 32'(rp));
    check({tag, ".dep"}, 32'(bus.ras_depth), 32'(depth));
    check({tag, ".err"}, 32'(bus.ras_err), 32'(err));
  endtask

  initial begin
    checks            = 0;
    errors            = 0;
    reset             = 1'b1;
    bus.start         = 1'b0;
    bus.start_address = '0;
    bus.op            = PC_NOP;
    bus.zero          = 1'b0;
    bus.res           = '0;
    bus.rz            = '0;
    bus.lj_page       = '0;
    bus.subroutine    = '0;
`ifdef PC_STALL_EN
    bus.stall         = 1'b0;
`endif

    // 1. reset and free-running increment
    step();
    step();
    chk3("reset", 10'h000, 0, 1'b0);
    reset = 1'b0;
    step(); check("nop1", 32'(bus.rp), 32'h001);
    step(); check("nop2", 32'(bus.rp), 32'h002);
    step(); check("nop3", 32'(bus.rp), 32'h003);
    reset = 1'b1;
    #2;
    check("async_rst", 32'(bus.rp), 32'h000);
    reset = 1'b0;
    step();

    // 2. start and register jumps
    do_start(10'h100);
    chk3("start", 10'h100, 0, 1'b0);
    bus.res  = 10'h0CC;
    bus.zero = 1'b1;
    do_op(PC_JIZR); check("jizr_taken", 32'(bus.rp), 32'h0CC);
    bus.zero = 1'b0;
    do_op(PC_JIZR); check("jizr_not", 32'(bus.rp), 32'h0CD);
    bus.res  = 10'h0CC;
    do_op(PC_JNZR); check("jnzr_taken", 32'(bus.rp), 32'h0CC);

    // 3. page-relative branches, long jump, wrap
    bus.rz   = 8'hF0;
    bus.zero = 1'b0;
    do_op(PC_BNZR); check("bnzr_pg0", 32'(bus.rp), 32'h0F0);
    do_start(10'h2CC);
    do_op(PC_BNZR); check("bnzr_pg2", 32'(bus.rp), 32'h2F0);
    bus.zero = 1'b1;
    do_op(PC_BNZR); check("bnzr_not", 32'(bus.rp), 32'h2F1);
    bus.rz   = 8'h10;
    do_op(PC_BIZR); check("bizr_taken", 32'(bus.rp), 32'h210);
    bus.lj_page = 2'd3;
    bus.rz      = 8'hF0;
    do_op(PC_LJ); check("lj", 32'(bus.rp), 32'h3F0);
    do_start(10'h3FF);
    do_op(PC_NOP); check("wrap", 32'(bus.rp), 32'h000);
    bus.zero = 1'b1;
    do_op(PC_JNZR); check("jnzr_not", 32'(bus.rp), 32'h001);

    // 4. nested call / return
    do_start(10'h010);
    bus.subroutine = 10'h21C;
    do_op(PC_CALL); chk3("call1", 10'h21C, 1, 1'b0);
    bus.subroutine = 10'h300;
    do_op(PC_CALL); chk3("call2", 10'h300, 2, 1'b0);
    do_op(PC_RET);  chk3("ret2", 10'h21D, 1, 1'b0);
    do_op(PC_RET);  chk3("ret1", 10'h011, 0, 1'b0);

    // 5. overflow and underflow
    do_start(10'h040);
    bus.subroutine = 10'h100; do_op(PC_CALL);
    bus.subroutine = 10'h200; do_op(PC_CALL);
    bus.subroutine = 10'h300; do_op(PC_CALL);
    bus.subroutine = 10'h050; do_op(PC_CALL);
    chk3("call_full", 10'h050, 4, 1'b0);
    bus.subroutine = 10'h060; do_op(PC_CALL);
    chk3("call_ovf", 10'h060, 4, 1'b1);
    do_op(PC_RET); chk3("pop4", 10'h301, 3, 1'b1);
    do_op(PC_RET); chk3("pop3", 10'h201, 2, 1'b1);
    do_op(PC_RET); chk3("pop2", 10'h101, 1, 1'b1);
    do_op(PC_RET); chk3("pop1", 10'h041, 0, 1'b1);
    do_op(PC_RET); chk3("pop_unf", 10'h042, 0, 1'b1);
    do_start(10'h000);
    chk3("start_clr", 10'h000, 0, 1'b0);
    do_op(PC_RET); chk3("unf_only", 10'h001, 0, 1'b1);

    // return address wraps when calling from the top of memory
    do_start(10'h3FF);
    bus.subroutine = 10'h123;
    do_op(PC_CALL); chk3("call_top", 10'h123, 1, 1'b0);
    do_op(PC_RET);  chk3("ret_wrap", 10'h000, 0, 1'b0);

`ifdef PC_STALL_EN
    // 6. stall holds everything except start
    do_start(10'h080);
    bus.subroutine = 10'h123;
    do_op(PC_CALL); chk3("st_call", 10'h123, 1, 1'b0);
    bus.stall      = 1'b1;
    bus.subroutine = 10'h200;
    do_op(PC_CALL); chk3("st_hold_call", 10'h123, 1, 1'b0);
    do_op(PC_RET);  chk3("st_hold_ret", 10'h123, 1, 1'b0);
    do_start(10'h155);
    chk3("st_start", 10'h155, 0, 1'b0);
    bus.stall = 1'b0;
    do_op(PC_NOP); check("st_release", 32'(bus.rp), 32'h156);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
